serial_add_scheduler: RTL and testbench



---
 rtl/serial_add_scheduler.sv | 251 +++++++++++++++++++++++++
 tb/tb_serial_add_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_scheduler
//  Description : Bit-serial adder controller. A single 1-bit full-adder cell
//                is shared between NUM_REQ requesters. Requests are
//                arbitrated round-robin. The winner's operands are latched
//                and added LSB-first over WIDTH cycles, with the carry held
//                in a flop between cycles. The result is returned on a
//                valid/ready response port.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH    operand width in bits (>= 2)
//    NUM_REQ  number of requesters (>= 2)
//    ID_W     requester ID width
//
//  Ports
//    clk_i        clock, rising edge
//    reset_i      asynchronous active-high reset
//    req_valid_i  per-requester request valid
//    req_ready_o  per-requester accept; one-hot or zero, IDLE only
//    req_a_i      operand A, requester k at [k*WIDTH +: WIDTH]
//    req_b_i      operand B, same packing
//    req_cin_i    per-requester carry-in
//    rsp_valid_o  result available
//    rsp_ready_i  consumer accepts the result
//    rsp_sum_o    (A + B + cin) mod 2^WIDTH
//    rsp_cout_o   carry out of the MSB
//    rsp_id_o     requester that owns the result
//    rsp_ovf_o    signed overflow (only with SERIAL_ADD_OVF_EN)
//
//  Build option
//    SERIAL_ADD_OVF_EN  when defined, adds the rsp_ovf_o port and the flop
//                       that holds the carry into the MSB.
// ============================================================================
module serial_add_scheduler #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
  input  logic [NUM_REQ-1:0]       req_cin_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [WIDTH-1:0]         rsp_sum_o,
  output logic                     rsp_cout_o,
  output logic [ID_W-1:0]          rsp_id_o
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic                     rsp_ovf_o
`endif
);

  localparam int              C_CNT_W   = $clog2(WIDTH);
  localparam logic [C_CNT_W-1:0] C_LAST_BIT = C_CNT_W'(WIDTH - 1);
  localparam logic [ID_W-1:0] C_RR_RESET = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t              state_q,     state_d;
  logic [ID_W-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [C_CNT_W-1:0]  cnt_q,       cnt_d;
  logic                carry_q,     carry_d;
  logic [WIDTH-1:0]    a_q,         a_d;
  logic [WIDTH-1:0]    b_q,         b_d;
  logic [WIDTH-1:0]    sum_q,       sum_d;
  logic [ID_W-1:0]     id_q,        id_d;
  logic                rsp_valid_q, rsp_valid_d;
`ifdef SERIAL_ADD_OVF_EN
  logic                msb_cin_q,   msb_cin_d;
`endif

  // --------------------------------------------------------------------------
  // Per-requester operand views
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] req_a_arr [NUM_REQ];
  logic [WIDTH-1:0] req_b_arr [NUM_REQ];

  generate
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign req_a_arr[k] = req_a_i[k*WIDTH +: WIDTH];
      assign req_b_arr[k] = req_b_i[k*WIDTH +: WIDTH];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Round-robin arbiter: first valid requester after rr_ptr, wrapping.
  // --------------------------------------------------------------------------
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] cand;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Ready is combinational on req_valid_i; it is also masked during reset so
  // nothing is offered while the block is being cleared.
  logic accept;

  always_comb begin
    req_ready_o = '0;
    accept      = 1'b0;
    if ((state_q == ST_IDLE) && grant_found && !reset_i) begin
      req_ready_o[grant_idx] = 1'b1;
      accept                 = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Shared 1-bit full-adder cell. Operand registers shift right each ADD
  // cycle so bit 0 is always the bit currently being added.
  // --------------------------------------------------------------------------
  logic fa_sum;
  logic fa_cout;

  assign fa_sum  = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_cout = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
`ifdef SERIAL_ADD_OVF_EN
    msb_cin_d   = msb_cin_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d      = req_a_arr[grant_idx];
          b_d      = req_b_arr[grant_idx];
          carry_d  = req_cin_i[grant_idx];
          id_d     = grant_idx;
          rr_ptr_d = grant_idx;
          cnt_d    = '0;
          sum_d    = '0;
          state_d  = ST_ADD;
        end
      end

      ST_ADD: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        // Sum bits enter at the MSB and move down; after WIDTH shifts the
        // bit produced in cycle i sits at position i.
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == C_LAST_BIT) begin
`ifdef SERIAL_ADD_OVF_EN
          // Carry flop still holds the carry into the MSB this cycle.
          msb_cin_d   = carry_q;
`endif
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= C_RR_RESET;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      msb_cin_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef SERIAL_ADD_OVF_EN
      msb_cin_q   <= msb_cin_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Response outputs. After the last bit the carry flop holds the carry out
  // of the MSB, and nothing touches it again until the next accept.
  // --------------------------------------------------------------------------
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_sum_o   = sum_q;
  assign rsp_cout_o  = carry_q;
  assign rsp_id_o    = id_q;
`ifdef SERIAL_ADD_OVF_EN
  assign rsp_ovf_o   = msb_cin_q ^ carry_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_add_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_scheduler
//  Description : Self-checking bench for serial_add_scheduler with directed
//                scenarios and randomized transactions against a reference
//                model (arithmetic sum, round-robin grant order).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_scheduler;

  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic                     clk = 1'b0;
  logic                     reset_i;
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ*WIDTH-1:0] req_a_i;
  logic [NUM_REQ*WIDTH-1:0] req_b_i;
  logic [NUM_REQ-1:0]       req_cin_i;
  logic                     rsp_valid_o;
  logic                     rsp_ready_i;
  logic [WIDTH-1:0]         rsp_sum_o;
  logic                     rsp_cout_o;
  logic [ID_W-1:0]          rsp_id_o;
`ifdef SERIAL_ADD_OVF_EN
  logic                     rsp_ovf_o;
`endif

  serial_add_scheduler #(
    .WIDTH   (WIDTH),
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .req_cin_i   (req_cin_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_sum_o   (rsp_sum_o),
    .rsp_cout_o  (rsp_cout_o),
    .rsp_id_o    (rsp_id_o)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .rsp_ovf_o   (rsp_ovf_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] op_a [NUM_REQ];
  logic [WIDTH-1:0] op_b [NUM_REQ];
  logic             op_c [NUM_REQ];
  int               rr_model;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic cur_ovf();
`ifdef SERIAL_ADD_OVF_EN
    return rsp_ovf_o;
`else
    return 1'b0;
`endif
  endfunction

  // Round-robin reference: walk requesters in order starting after the last
  // winner and take the first one asking.
  function automatic int pick(input logic [NUM_REQ-1:0] mask, input int last);
    int order[$];
    for (int k = 1; k <= NUM_REQ; k++) order.push_back((last + k) % NUM_REQ);
    foreach (order[j]) if (mask[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic drive_ops();
    for (int k = 0; k < NUM_REQ; k++) begin
      req_a_i[k*WIDTH +: WIDTH] = op_a[k];
      req_b_i[k*WIDTH +: WIDTH] = op_b[k];
      req_cin_i[k]              = op_c[k];
    end
  endtask

  task automatic idle_cycles(input int n);
    req_valid_i = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_ready", req_ready_o, 0);
      check("idle_valid", rsp_valid_o, 0);
    end
  endtask

  // One full transaction, called at a negedge with the DUT in IDLE. Returns
  // at the negedge after the response handshake, valids still asserted.
  task automatic run_add(input logic [NUM_REQ-1:0] mask, input int hold,
                         output int g, output time acc_t,
                         output logic [WIDTH-1:0] o_sum, output logic o_cout,
                         output logic o_ovf);
    int               n;
    logic [WIDTH:0]   full;
    logic             exp_ovf;
    drive_ops();
    req_valid_i = mask;
    rsp_ready_i = (hold == 0);
    #1;
    g = pick(mask, rr_model);
    check("grant_ready", req_ready_o, 32'(1) << g);
    full    = {1'b0, op_a[g]} + {1'b0, op_b[g]} + (WIDTH+1)'(op_c[g]);
    exp_ovf = (op_a[g][WIDTH-1] == op_b[g][WIDTH-1]) && (full[WIDTH-1] != op_a[g][WIDTH-1]);
    @(posedge clk);
    acc_t    = $time;
    rr_model = g;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      check("busy_ready", req_ready_o, 0);
    end while (!rsp_valid_o && n < 20);
    check("latency", n, WIDTH + 1);
    o_sum  = rsp_sum_o;
    o_cout = rsp_cout_o;
    o_ovf  = cur_ovf();
    check("sum",  rsp_sum_o,  full[WIDTH-1:0]);
    check("cout", rsp_cout_o, full[WIDTH]);
    check("id",   rsp_id_o,   g);
`ifdef SERIAL_ADD_OVF_EN
    check("ovf",  rsp_ovf_o,  exp_ovf);
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid_o, 1);
      check("hold_sum",   rsp_sum_o,   full[WIDTH-1:0]);
      check("hold_cout",  rsp_cout_o,  full[WIDTH]);
      check("hold_id",    rsp_id_o,    g);
      check("hold_ready", req_ready_o, 0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    check("rsp_drop", rsp_valid_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int               g;
    time              t [4];
    logic [WIDTH-1:0] s;
    logic             co, ov;
    logic [NUM_REQ-1:0] m;

    // ---------------- reset ----------------
    reset_i     = 1'b1;
    req_valid_i = '1;
    rsp_ready_i = 1'b0;
    req_a_i     = '1;
    req_b_i     = '1;
    req_cin_i   = '1;
    #1;
    check("rst_ready", req_ready_o, 0);
    check("rst_valid", rsp_valid_o, 0);
    check("rst_sum",   rsp_sum_o,   0);
    check("rst_cout",  rsp_cout_o,  0);
    check("rst_id",    rsp_id_o,    0);
    check("rst_ovf",   cur_ovf(),   0);
    repeat (2) @(negedge clk);
    req_valid_i = '0;
    reset_i     = 1'b0;
    rr_model    = NUM_REQ - 1;
    idle_cycles(2);

    // ---------------- single add ----------------
    op_a[0] = 8'h5A; op_b[0] = 8'h3C; op_c[0] = 1'b0;
    op_a[1] = 8'h00; op_b[1] = 8'h00; op_c[1] = 1'b0;
    run_add(2'b01, 0, g, t[0], s, co, ov);
    check("single_sum",  s,  8'h96);
    check("single_cout", co, 0);
    check("single_id",   g,  0);
    idle_cycles(1);

    // ---------------- carry chain ----------------
    op_a[1] = 8'hFF; op_b[1] = 8'h01; op_c[1] = 1'b0;
    run_add(2'b10, 0, g, t[0], s, co, ov);
    check("chain1_sum",  s,  8'h00);
    check("chain1_cout", co, 1);
    check("chain1_id",   g,  1);
    idle_cycles(1);
    op_a[1] = 8'hFF; op_b[1] = 8'hFF; op_c[1] = 1'b1;
    run_add(2'b10, 0, g, t[0], s, co, ov);
    check("chain2_sum",  s,  8'hFF);
    check("chain2_cout", co, 1);
    idle_cycles(1);

    // ---------------- fairness ----------------
    op_a[0] = 8'h11; op_b[0] = 8'h22; op_c[0] = 1'b1;
    op_a[1] = 8'h33; op_b[1] = 8'h44; op_c[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_add(2'b11, 0, g, t[i], s, co, ov);
      check("fair_order", g, i % 2);
      if (i > 0) check("fair_spacing", int'((t[i] - t[i-1]) / 10), WIDTH + 2);
    end
    idle_cycles(1);

    // ---------------- backpressure ----------------
    op_a[0] = 8'hA5; op_b[0] = 8'h5A; op_c[0] = 1'b1;
    run_add(2'b11, 5, g, t[0], s, co, ov);
    check("bp_sum", s, 8'h00);
    check("bp_cout", co, 1);
    idle_cycles(1);

    // ---------------- reset mid-op ----------------
    op_a[1] = 8'hF0; op_b[1] = 8'h0E; op_c[1] = 1'b1;
    drive_ops();
    req_valid_i = 2'b10;
    @(posedge clk);
    req_valid_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_i     = 1'b1;
    req_valid_i = 2'b11;
    #1;
    check("mid_rst_valid", rsp_valid_o, 0);
    check("mid_rst_sum",   rsp_sum_o,   0);
    check("mid_rst_cout",  rsp_cout_o,  0);
    check("mid_rst_id",    rsp_id_o,    0);
    check("mid_rst_ready", req_ready_o, 0);
    check("mid_rst_ovf",   cur_ovf(),   0);
    repeat (2) @(negedge clk);
    req_valid_i = '0;
    reset_i     = 1'b0;
    rr_model    = NUM_REQ - 1;
    idle_cycles(12);
    op_a[0] = 8'h01; op_b[0] = 8'h02; op_c[0] = 1'b0;
    run_add(2'b11, 0, g, t[0], s, co, ov);
    check("post_rst_sum", s, 8'h03);
    check("post_rst_id",  g, 0);
    idle_cycles(1);

`ifdef SERIAL_ADD_OVF_EN
    // ---------------- signed overflow ----------------
    op_a[0] = 8'h7F; op_b[0] = 8'h01; op_c[0] = 1'b0;
    run_add(2'b01, 0, g, t[0], s, co, ov);
    check("ovf1_sum", s, 8'h80); check("ovf1_ovf", ov, 1); check("ovf1_cout", co, 0);
    idle_cycles(1);
    op_a[0] = 8'h80; op_b[0] = 8'h80;
    run_add(2'b01, 0, g, t[0], s, co, ov);
    check("ovf2_sum", s, 8'h00); check("ovf2_ovf", ov, 1); check("ovf2_cout", co, 1);
    idle_cycles(1);
    op_a[0] = 8'h10; op_b[0] = 8'h20;
    run_add(2'b01, 0, g, t[0], s, co, ov);
    check("ovf3_ovf", ov, 0);
    idle_cycles(1);
`endif

    // ---------------- randomized ----------------
    for (int it = 0; it < 60; it++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        op_a[k] = WIDTH'($urandom);
        op_b[k] = WIDTH'($urandom);
        op_c[k] = 1'($urandom);
      end
      m = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      run_add(m, int'($urandom_range(0, 3)), g, t[0], s, co, ov);
      if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 2)));
    end
    idle_cycles(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
